// File: rtl/s_mem_sequential_reader.sv
// s_mem_sequential_reader: read-only ascending sweep of S memory onto a valid/ready byte stream.
// Optional identity check (S[i] == i) is enabled by defining S_MEM_IDENTITY_CHECK_EN.
module s_mem_sequential_reader #(
    parameter int READ_LATENCY = 1,
    parameter int DEPTH        = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] address_out,
    output logic       write_enable_out,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] index_out,
    output logic       data_valid_out,
    input  logic       data_ready_in,
    output logic       busy_out,
    output logic       read_done,
    output logic       mismatch_out,
    output logic [7:0] first_bad_index_out,
    output logic [8:0] mismatch_count_out
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(DEPTH - 1);
    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    state_t     state_q;
    logic [8:0] idx_q;
    logic [1:0] lat_q;
    logic [7:0] data_q;
    logic [7:0] index_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;
    logic       start_ok;
    logic       capture;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign capture  = (state_q == WAIT) && (lat_q == 2'd0);

    // Address only moves on entry to ISSUE, so RAM q is stable through WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q <= ISSUE;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    lat_q   <= LAT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        data_q  <= data_in;
                        index_q <= idx_q[7:0];
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                PRESENT: begin
                    if (data_ready_in) begin
                        valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 9'd1;
                            state_q <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign address_out      = idx_q[7:0];
    assign write_enable_out = 1'b0;
    assign data_out         = data_q;
    assign index_out        = index_q;
    assign data_valid_out   = valid_q;
    assign busy_out         = busy_q;
    assign read_done        = done_q;

`ifdef S_MEM_IDENTITY_CHECK_EN
    logic       mism_q;
    logic [7:0] first_q;
    logic [8:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mism_q  <= 1'b0;
            first_q <= '0;
            cnt_q   <= '0;
        end else if (start_ok) begin
            mism_q  <= 1'b0;
            first_q <= '0;
            cnt_q   <= '0;
        end else if (capture && data_in != idx_q[7:0]) begin
            if (!mism_q) begin
                mism_q  <= 1'b1;
                first_q <= idx_q[7:0];
            end
            if (cnt_q != 9'd256) begin
                cnt_q <= cnt_q + 9'd1;
            end
        end
    end

    assign mismatch_out        = mism_q;
    assign first_bad_index_out = first_q;
    assign mismatch_count_out  = cnt_q;
`else
    assign mismatch_out        = 1'b0;
    assign first_bad_index_out = '0;
    assign mismatch_count_out  = '0;
`endif

endmodule

// File: tb/tb_s_mem_sequential_reader.sv
// Bench for s_mem_sequential_reader: two DUTs (latency 1 and 3) with RAM models,
// a stream scoreboard checked every cycle, and directed sweep scenarios.
module tb_s_mem_sequential_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       start [2];
    logic       rdy   [2];
    logic [7:0] addr  [2];
    logic [7:0] dout  [2];
    logic [7:0] idx   [2];
    logic [7:0] fbi   [2];
    logic       we    [2];
    logic       dv    [2];
    logic       busy  [2];
    logic       done  [2];
    logic       mm    [2];
    logic [8:0] mcnt  [2];
    logic [7:0] mem   [2][256];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         exp_idx [2];
    int         hs_cnt  [2];
    int         hs_t    [2][256];
    logic       pv      [2];
    logic       pr      [2];
    logic [7:0] pd      [2];
    logic [7:0] pi      [2];

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [7:0] p [4];
        always @(posedge clk) begin
            p[0] <= mem[g][addr[g]];
            for (int j = 1; j < 4; j++) p[j] <= p[j-1];
        end
        s_mem_sequential_reader #(.READ_LATENCY(L), .DEPTH(256)) u_dut (
            .clk                 (clk),
            .reset               (rst[g]),
            .start               (start[g]),
            .address_out         (addr[g]),
            .write_enable_out    (we[g]),
            .data_in             (p[L-1]),
            .data_out            (dout[g]),
            .index_out           (idx[g]),
            .data_valid_out      (dv[g]),
            .data_ready_in       (rdy[g]),
            .busy_out            (busy[g]),
            .read_done           (done[g]),
            .mismatch_out        (mm[g]),
            .first_bad_index_out (fbi[g]),
            .mismatch_count_out  (mcnt[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard: stream must deliver S[0..255] in order, stable while stalled.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                exp_idx[k] = 0;
                pv[k] = 1'b0;
            end else begin
                chk("we_low", we[k], 0);
                if (pv[k] && !pr[k]) begin
                    chk("hold_valid", dv[k], 1);
                    chk("hold_data", dout[k], pd[k]);
                    chk("hold_index", idx[k], pi[k]);
                end
                if (dv[k] && rdy[k]) begin
                    chk("hs_index", idx[k], exp_idx[k]);
                    chk("hs_data", dout[k], mem[k][exp_idx[k] & 255]);
                    chk("hs_busy", busy[k], 1);
                    if (exp_idx[k] < 256) hs_t[k][exp_idx[k]] = cyc;
                    exp_idx[k]++;
                    hs_cnt[k]++;
                end
                pv[k] = dv[k];
                pr[k] = rdy[k];
                pd[k] = dout[k];
                pi[k] = idx[k];
            end
        end
    end

    task automatic run_start(input int k, output int s);
        hs_cnt[k] = 0;
        exp_idx[k] = 0;
        start[k] = 1'b1;
        s = cyc + 1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int t);
        int n = 0;
        while (!done[k] && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        t = cyc;
        if (!done[k]) chk("done_timeout", 0, 1);
    endtask

    task automatic check_cadence(input int k, input int s, input int lat);
        chk("first_hs_lat", hs_t[k][0] + 1 - s, lat + 2);
        for (int i = 1; i < 256; i++)
            chk("cadence", hs_t[k][i] - hs_t[k][i-1], lat + 2);
    endtask

    initial begin
        int s, t, n, ec, ef;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            start[k] = 1'b0;
            rdy[k] = 1'b1;
            exp_idx[k] = 0;
            hs_cnt[k] = 0;
            pv[k] = 1'b0;
        end
        for (int i = 0; i < 256; i++) begin
            mem[0][i] = 8'(i);
            mem[1][i] = 8'(255 - i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", addr[0], 0);
        chk("rst_index", idx[0], 0);
        chk("rst_data", dout[0], 0);
        chk("rst_valid", dv[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_mm", mm[0], 0);
        chk("rst_fbi", fbi[0], 0);
        chk("rst_mcnt", mcnt[0], 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // Full sweep, latency 1, ready always high.
        run_start(0, s);
        chk("start_busy", busy[0], 1);
        wait_done(0, t);
        chk("sweep_cycles_l1", t - s, 768);
        chk("hs_count_l1", hs_cnt[0], 256);
        chk("done_busy", busy[0], 0);
        chk("done_valid", dv[0], 0);
        chk("clean_mcnt", mcnt[0], 0);
        check_cadence(0, s, 1);

        // Restart from DONE; stall 10 cycles at index 37 with a start pulse in PRESENT.
        run_start(0, s);
        chk("restart_done_clr", done[0], 0);
        chk("restart_busy", busy[0], 1);
        n = 0;
        while (!(dv[0] && idx[0] == 8'd37) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_37", idx[0], 37);
        rdy[0] = 1'b0;
        start[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            start[0] = 1'b0;
            chk("stall_valid", dv[0], 1);
            chk("stall_index", idx[0], 37);
            chk("stall_data", dout[0], 37);
        end
        rdy[0] = 1'b1;
        wait_done(0, t);
        chk("hs_count_stall", hs_cnt[0], 256);

        // Latency 3, S[i] = 255 - i.
        run_start(1, s);
        wait_done(1, t);
        chk("hs_count_l3", hs_cnt[1], 256);
        chk("last_hs_l3", hs_t[1][255] + 1 - s, 1280);
        chk("first_data_l3", mem[1][0], 255);
        check_cadence(1, s, 3);

        // Identity-check corruption.
        mem[0][100] = 8'd7;
        mem[0][200] = 8'd0;
        run_start(0, s);
        wait_done(0, t);
        chk("hs_count_bad", hs_cnt[0], 256);
        ec = 0;
        ef = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[0][i] != 8'(i)) begin
                if (ec == 0) ef = i;
                ec++;
            end
        end
`ifndef S_MEM_IDENTITY_CHECK_EN
        ec = 0;
        ef = 0;
`endif
        chk("mm_flag", mm[0], (ec != 0) ? 1 : 0);
        chk("mm_first", fbi[0], ef);
        chk("mm_count", mcnt[0], ec);
`ifdef S_MEM_IDENTITY_CHECK_EN
        chk("mm_count_lit", mcnt[0], 2);
        chk("mm_first_lit", fbi[0], 100);
`else
        chk("mm_count_lit", mcnt[0], 0);
        chk("mm_first_lit", fbi[0], 0);
`endif
        mem[0][100] = 8'd100;
        mem[0][200] = 8'd200;

        // Reset asserted during WAIT at index 50, then a fresh sweep.
        run_start(0, s);
        chk("start_clr_mcnt", mcnt[0], 0);
        chk("start_clr_mm", mm[0], 0);
        n = 0;
        while (!(addr[0] == 8'd50 && !dv[0]) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_50", addr[0], 50);
        @(posedge clk);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("arst_addr", addr[0], 0);
        chk("arst_index", idx[0], 0);
        chk("arst_data", dout[0], 0);
        chk("arst_valid", dv[0], 0);
        chk("arst_busy", busy[0], 0);
        chk("arst_done", done[0], 0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(posedge clk);
        #1;
        run_start(0, s);
        wait_done(0, t);
        chk("hs_count_after_rst", hs_cnt[0], 256);
        chk("sweep_cycles_after_rst", t - s, 768);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
